// File: rtl/gng_meter_pkg.sv
// Shared types and width helpers for the complex noise statistics meter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package gng_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Cycles needed after the last accepted sample for it to reach the accumulators
  localparam int DRAIN_CYCLES = 2;
  localparam int DRAIN_W      = $clog2(DRAIN_CYCLES);

  // I/Q sum width: one extra bit per doubling of the block, so -2^(DW-1)*N still fits
  function automatic int sum_width(input int dw, input int log2_n);
    return dw + log2_n;
  endfunction

  // Power sum width: each I^2+Q^2 term is at most 2^(2*DW-1), times N samples
  function automatic int pwr_width(input int dw, input int log2_n);
    return 2 * dw + log2_n;
  endfunction

endpackage

// File: rtl/gng_meter_sq.sv
// Registered signed squarer, result reinterpreted as unsigned magnitude.
// Latency: 1 cycle.
// Backpressure: none; computes every cycle.
module gng_meter_sq #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] x,
  output logic [2*DW-1:0]      sq
);

  logic signed [2*DW-1:0] x_ext;
  logic signed [2*DW-1:0] prod;

  // Widen before multiplying so the full product is kept; x^2 <= 2^(2*DW-2) never wraps
  assign x_ext = {{DW{x[DW-1]}}, x};
  assign prod  = x_ext * x_ext;

  // Register the square
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sq <= '0;
    else     sq <= prod;
  end

endmodule

// File: rtl/gng_cmplx_meter.sv
// Block statistics (sum I, sum Q, sum I^2+Q^2, optional peak |I|,|Q| with GNG_METER_PEAK_EN) over 2^LOG2_N samples.
// Latency: result valid 3 cycles after the cycle carrying the last sample.
// Backpressure: result held in DONE until res_ready; samples are never stalled, only ignored outside ACCUM.
module gng_cmplx_meter
  import gng_meter_pkg::*;
#(
  parameter int LOG2_N = 10,
  parameter int DW     = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      valid_in,
  input  logic signed [DW-1:0]                      real_in,
  input  logic signed [DW-1:0]                      imag_in,
  output logic                                      busy,
  output logic                                      res_valid,
  input  logic                                      res_ready,
  output logic signed [sum_width(DW, LOG2_N)-1:0]   sum_i,
  output logic signed [sum_width(DW, LOG2_N)-1:0]   sum_q,
`ifdef GNG_METER_PEAK_EN
  output logic [DW-1:0]                             peak_i,
  output logic [DW-1:0]                             peak_q,
`endif
  output logic [pwr_width(DW, LOG2_N)-1:0]          sum_pwr
);

  localparam int SW = sum_width(DW, LOG2_N);
  localparam int PW = pwr_width(DW, LOG2_N);

  state_t               state;
  state_t               state_nxt;
  logic [LOG2_N-1:0]    cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 accept;
  logic                 clear;

  logic                 s1_vld;
  logic signed [DW-1:0] s1_i;
  logic signed [DW-1:0] s1_q;
  logic                 s2_vld;
  logic signed [DW-1:0] s2_i;
  logic signed [DW-1:0] s2_q;
  logic [2*DW-1:0]      sq_i;
  logic [2*DW-1:0]      sq_q;

  assign accept = valid_in && (state == ACCUM);
  assign clear  = start && (state == IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: last sample leaves ACCUM, drain lets the pipeline empty into the sums
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (accept && (cnt == '1)) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy      = (state != IDLE);
    res_valid = (state == DONE);
  end

  // Sample and drain counters; the sample counter wraps to 0 on the last sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      drain_cnt <= '0;
    end else begin
      if (clear)       cnt <= '0;
      else if (accept) cnt <= cnt + LOG2_N'(1);
      if (state == DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
      else                drain_cnt <= '0;
    end
  end

  // Stage 1: capture accepted samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_i   <= '0;
      s1_q   <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_i <= real_in;
        s1_q <= imag_in;
      end
    end
  end

  gng_meter_sq #(.DW(DW)) u_sq_i (.clk(clk), .rst(rst), .x(s1_i), .sq(sq_i));
  gng_meter_sq #(.DW(DW)) u_sq_q (.clk(clk), .rst(rst), .x(s1_q), .sq(sq_q));

  // Stage 2: carry I/Q alongside the registered squares
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_i   <= '0;
      s2_q   <= '0;
    end else begin
      s2_vld <= s1_vld;
      s2_i   <= s1_i;
      s2_q   <= s1_q;
    end
  end

  // Stage 3: accumulate; cleared when a new block is started
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_i   <= '0;
      sum_q   <= '0;
      sum_pwr <= '0;
    end else if (clear) begin
      sum_i   <= '0;
      sum_q   <= '0;
      sum_pwr <= '0;
    end else if (s2_vld) begin
      sum_i   <= sum_i + SW'(s2_i);
      sum_q   <= sum_q + SW'(s2_q);
      sum_pwr <= sum_pwr + PW'(sq_i) + PW'(sq_q);
    end
  end

`ifdef GNG_METER_PEAK_EN
  // |x| in DW bits: -2^(DW-1) maps to 2^(DW-1), which still fits unsigned
  function automatic logic [DW-1:0] mag(input logic signed [DW-1:0] x);
    logic [DW-1:0] u;
    u = x;
    return x[DW-1] ? (~u + DW'(1)) : u;
  endfunction

  // Track peak magnitudes alongside the sums
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_i <= '0;
      peak_q <= '0;
    end else if (clear) begin
      peak_i <= '0;
      peak_q <= '0;
    end else if (s2_vld) begin
      if (mag(s2_i) > peak_i) peak_i <= mag(s2_i);
      if (mag(s2_q) > peak_q) peak_q <= mag(s2_q);
    end
  end
`endif

endmodule
